// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters, pixel request port, registered sync/DE/colour.
// Define VGA_TEST_PATTERN_EN to build in an 8-bar colour test pattern selected by test_mode.
module vga_timing_gen #(
    parameter int   H_DISP  = 640,
    parameter int   H_FP    = 16,
    parameter int   H_SYNC  = 96,
    parameter int   H_BP    = 48,
    parameter int   V_DISP  = 480,
    parameter int   V_FP    = 10,
    parameter int   V_SYNC  = 2,
    parameter int   V_BP    = 33,
    parameter logic HS_POL  = 1'b0,
    parameter logic VS_POL  = 1'b0,
    parameter int   COLOR_W = 3,
    parameter int   CNT_W   = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    input  logic               test_mode,
    input  logic [COLOR_W-1:0] rgb_in,
    output logic [CNT_W-1:0]   req_x,
    output logic [CNT_W-1:0]   req_y,
    output logic               req_valid,
    output logic [COLOR_W-1:0] rgb_out,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int F       = COLOR_W / 3;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISP + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISP + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISP + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISP + V_FP + V_SYNC);

    logic [CNT_W-1:0]   h_cnt;
    logic [CNT_W-1:0]   v_cnt;
    logic               h_wrap;
    logic               v_wrap;
    logic               visible;
    logic               hs_act;
    logic               vs_act;
    logic [COLOR_W-1:0] pix_color;

    assign h_wrap  = (h_cnt == H_LAST);
    assign v_wrap  = (v_cnt == V_LAST);
    assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_act  = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_act  = (v_cnt >= VS_START) && (v_cnt < VS_END);

    assign req_x     = h_cnt;
    assign req_y     = v_cnt;
    assign req_valid = visible;

`ifdef VGA_TEST_PATTERN_EN
    // Bar index is floor(h_cnt*8/H_DISP), found by comparing against the seven bar boundaries.
    logic [2:0]       bar;
    logic [CNT_W+2:0] h_x8;

    assign h_x8 = {h_cnt, 3'b000};

    always_comb begin
        bar = '0;
        for (int i = 1; i < 8; i++) begin
            if (32'(h_x8) >= i * H_DISP) begin
                bar = 3'(i);
            end
        end
    end

    assign pix_color = test_mode ? {{F{bar[2]}}, {F{bar[1]}}, {F{bar[0]}}} : rgb_in;
`else
    logic unused_test_mode;

    assign unused_test_mode = test_mode;
    assign pix_color        = rgb_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Outputs decode the pre-increment position, so they trail req_* by one pix_en tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_out     <= '0;
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            rgb_out     <= visible ? pix_color : '0;
            de          <= visible;
            hsync       <= hs_act ? HS_POL : ~HS_POL;
            vsync       <= vs_act ? VS_POL : ~VS_POL;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 12x7 raster (8x4 visible, active-high syncs, 6-bit colour).
module tb_vga_timing_gen;

    logic        clk;
    logic        reset;
    logic        pix_en;
    logic        test_mode;
    logic [5:0]  rgb_in;
    logic [10:0] req_x;
    logic [10:0] req_y;
    logic        req_valid;
    logic [5:0]  rgb_out;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    vga_timing_gen #(
        .H_DISP(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(6), .CNT_W(11)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .test_mode(test_mode),
        .rgb_in(rgb_in), .req_x(req_x), .req_y(req_y), .req_valid(req_valid),
        .rgb_out(rgb_out), .hsync(hsync), .vsync(vsync), .de(de),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       pe;
        logic [5:0] rgb;
        int         x;
        int         y;
        logic       valid;
        logic       de;
        logic [5:0] orgb;
        logic       hs;
        logic       vs;
        logic       fs;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic pe);
        pix_en = pe;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int x, input int y, input logic valid,
                             input logic d, input logic [5:0] c, input logic hs,
                             input logic vs, input logic fs);
        check({tag, ".req_x"}, 32'(req_x), 32'(x));
        check({tag, ".req_y"}, 32'(req_y), 32'(y));
        check({tag, ".req_valid"}, 32'(req_valid), 32'(valid));
        check({tag, ".de"}, 32'(de), 32'(d));
        check({tag, ".rgb_out"}, 32'(rgb_out), 32'(c));
        check({tag, ".hsync"}, 32'(hsync), 32'(hs));
        check({tag, ".vsync"}, 32'(vsync), 32'(vs));
        check({tag, ".frame_start"}, 32'(frame_start), 32'(fs));
    endtask

    function automatic logic [5:0] bar_color(input int x);
        logic [2:0] b;
        b = 3'(x);
        return {{2{b[2]}}, {2{b[1]}}, {2{b[0]}}};
    endfunction

    initial begin
        int fs_cnt, hs_cnt, vs_cnt, de_cnt, first_fs, second_fs, pos;
        logic [5:0] exp_c;

        // Fields: n, pix_en, rgb_in, then expected x, y, valid, de, rgb_out, hsync, vsync, frame_start
        vecs[0]  = '{1,  1'b1, 6'h2d, 1,  0, 1'b1, 1'b1, 6'h2d, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1,  1'b0, 6'h12, 1,  0, 1'b1, 1'b1, 6'h2d, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1,  1'b1, 6'h12, 2,  0, 1'b1, 1'b1, 6'h12, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{6,  1'b1, 6'h3f, 8,  0, 1'b0, 1'b1, 6'h3f, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1,  1'b1, 6'h3f, 9,  0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1,  1'b1, 6'h3f, 10, 0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1,  1'b1, 6'h3f, 11, 0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1,  1'b1, 6'h3f, 0,  1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1,  1'b1, 6'h07, 1,  1, 1'b1, 1'b1, 6'h07, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{35, 1'b1, 6'h07, 0,  4, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1,  1'b1, 6'h07, 1,  4, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{11, 1'b1, 6'h07, 0,  5, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1,  1'b1, 6'h07, 1,  5, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{9,  1'b1, 6'h07, 10, 5, 1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{2,  1'b1, 6'h07, 0,  6, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1,  1'b1, 6'h07, 1,  6, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{11, 1'b1, 6'h07, 0,  0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1,  1'b1, 6'h21, 1,  0, 1'b1, 1'b1, 6'h21, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1,  1'b1, 6'h21, 2,  0, 1'b1, 1'b1, 6'h21, 1'b0, 1'b0, 1'b0};

        reset     = 1'b1;
        pix_en    = 1'b0;
        test_mode = 1'b0;
        rgb_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        for (int i = 0; i < 19; i++) begin
            rgb_in = vecs[i].rgb;
            for (int k = 0; k < vecs[i].n; k++) tick(vecs[i].pe);
            check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].valid, vecs[i].de,
                      vecs[i].orgb, vecs[i].hs, vecs[i].vs, vecs[i].fs);
        end

        // Two full frames from (2,0): per-frame pulse counts and frame period.
        fs_cnt = 0; hs_cnt = 0; vs_cnt = 0; de_cnt = 0; first_fs = -1; second_fs = -1;
        for (int t = 0; t < 168; t++) begin
            tick(1'b1);
            if (frame_start) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = t;
                else second_fs = t;
            end
            if (hsync) hs_cnt++;
            if (vsync) vs_cnt++;
            if (de) de_cnt++;
        end
        check("frame.fs_count", 32'(fs_cnt), 32'd2);
        check("frame.period", 32'(second_fs - first_fs), 32'd84);
        check("frame.hsync_ticks", 32'(hs_cnt), 32'd28);
        check("frame.vsync_ticks", 32'(vs_cnt), 32'd24);
        check("frame.de_ticks", 32'(de_cnt), 32'd64);

        // pix_en 1-of-4: counters move only on enabled cycles; position starts at (2,0).
        pos = 2;
        for (int c = 0; c < 48; c++) begin
            tick((c % 4) == 0);
            if ((c % 4) == 0) pos++;
            check($sformatf("slow%0d.req_x", c), 32'(req_x), 32'(pos % 12));
            check($sformatf("slow%0d.req_y", c), 32'(req_y), 32'((pos / 12) % 7));
        end
        check("slow.end_hsync", 32'(hsync), 32'd0);

        // Mid-frame reset at (5,1) while driving visible pixels.
        rgb_in = 6'h15;
        repeat (3) tick(1'b1);
        check_all("pre_rst", 5, 1, 1'b1, 1'b1, 6'h15, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick(1'b1);
        check_all("post_rst", 1, 0, 1'b1, 1'b1, 6'h15, 1'b0, 1'b0, 1'b1);

        // Test-mode sweep across line 1; without the pattern build test_mode is ignored.
        rgb_in    = 6'h2a;
        test_mode = 1'b1;
        repeat (11) tick(1'b1);
        for (int x = 0; x < 9; x++) begin
            tick(1'b1);
`ifdef VGA_TEST_PATTERN_EN
            exp_c = (x < 8) ? bar_color(x) : 6'h00;
`else
            exp_c = (x < 8) ? 6'h2a : 6'h00;
`endif
            check($sformatf("bar_x%0d.rgb_out", x), 32'(rgb_out), 32'(exp_c));
            check($sformatf("bar_x%0d.de", x), 32'(de), 32'(x < 8));
        end
        test_mode = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- H_DISP, 640, visible pixels/line
- H_FP, 16, h front porch
- H_SYNC, 96, h sync width
- H_BP, 48, h back porch
- V_DISP, 480, visible lines
- V_FP, 10, v front porch lines
- V_SYNC, 2, v sync lines
- V_BP, 33, v back porch lines
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- COLOR_W, 3, rgb width, multiple of 3, {R,G,B} equal fields
- CNT_W, 11, counter/coordinate width
REQ-002 SHALL have ports (name, direction, width, meaning), one per line; clock clk; reset reset, asynchronous, active-high:
- clk, in, 1, system clock
- reset, in, 1, async active-high reset
- pix_en, in, 1, pixel-tick enable; all state advances only when high
- test_mode, in, 1, select colour-bar pattern
- rgb_in, in, COLOR_W, pixel colour for position req_x/req_y
- req_x, out, CNT_W, current horizontal counter (combinational from registers)
- req_y, out, CNT_W, current vertical counter
- req_valid, out, 1, current counter position is visible
- rgb_out, out, COLOR_W, registered pixel colour
- hsync, out, 1, registered h sync
- vsync, out, 1, registered v sync
- de, out, 1, registered display enable
- frame_start, out, 1, registered one-tick pulse at pixel (0,0)

Function
REQ-003 SHALL use H_TOTAL=H_DISP+H_FP+H_SYNC+H_BP, V_TOTAL=V_DISP+V_FP+V_SYNC+V_BP; line order: display, front porch, sync, back porch.
REQ-004 SHALL hold h_cnt in 0..H_TOTAL-1; on pix_en, increment; H_TOTAL-1 wraps to 0 and advances v_cnt.
REQ-005 SHALL hold v_cnt in 0..V_TOTAL-1; V_TOTAL-1 wraps to 0 on the same tick h_cnt wraps.
REQ-006 SHALL drive req_x=h_cnt, req_y=v_cnt, req_valid=(h_cnt<H_DISP)&&(v_cnt<V_DISP).
REQ-007 SHALL, on each pix_en tick, register outputs decoded from the pre-increment (h_cnt,v_cnt): latency exactly one pix_en tick from req_* to rgb_out/hsync/vsync/de.
REQ-008 SHALL assert hsync=HS_POL iff H_DISP+H_FP <= h_cnt < H_DISP+H_FP+H_SYNC, else ~HS_POL.
REQ-009 SHALL assert vsync=VS_POL iff V_DISP+V_FP <= v_cnt < V_DISP+V_FP+V_SYNC for whole lines, else ~VS_POL.
REQ-010 SHALL register de=req_valid; rgb_out=rgb_in when req_valid, else 0.
REQ-011 SHALL pulse frame_start high for exactly one pix_en tick, registered from (h_cnt,v_cnt)=(0,0).
REQ-012 SHALL hold all registers when pix_en low; pix_en tied high is legal.

Reset
REQ-013 SHALL on reset, asynchronously: h_cnt=0, v_cnt=0, rgb_out=0, de=0, frame_start=0, hsync=~HS_POL, vsync=~VS_POL.
REQ-014 SHALL, on reset mid-frame, restart at (0,0); first pix_en tick after release outputs pixel (0,0) with frame_start=1.

Configuration
REQ-015 SHALL with VGA_TEST_PATTERN_EN defined: when test_mode=1 replace rgb_in by 8 vertical bars, bar index b=floor(h_cnt*8/H_DISP), each of R,G,B fields replicated from b[2],b[1],b[0]; blanking rule REQ-010 still applies.
REQ-016 SHALL without VGA_TEST_PATTERN_EN: test_mode ignored, no pattern logic synthesised.

Verification
REQ-017 Default params, pix_en=1, full frame -> 420000 ticks per frame_start; hsync low 96 ticks per 800; vsync low 1600 ticks per frame.
REQ-018 rgb_in=3'b101, watch line 0 -> de high ticks 1..640 after line start, rgb_out=101 during de, 000 otherwise.
REQ-019 pix_en toggling 1-of-4 -> same waveform stretched 4x, counters frozen on idle cycles.
REQ-020 Reset at (300,200) -> outputs to reset values immediately; next tick frame_start=1, de=1.
REQ-021 VGA_TEST_PATTERN_EN, test_mode=1 -> rgb_out 000 for x=0..79, 001 for x=80..159, ..., 111 for x=560..639.
REQ-022 HS_POL=1, VS_POL=1, H_DISP=8, H_FP=1, H_SYNC=2, H_BP=1, V_DISP=4, V_FP=1, V_SYNC=1, V_BP=1 -> hsync high at h=9..10, vsync high on line 5, 84 ticks per frame.
